fifo_wr_ctrl: RTL and testbench

Write-domain controller for the asynchronous FIFO. It owns the write pointer, drives the dual-port RAM write port, and generates full, almost_full, fill level and overflow flags. It exports the write pointer in Gray code to the read-domain 2-FF synchronizer. It consumes the read pointer (Gray, ADDRWIDTH+1 bits) after that pointer has been synchronized into the write clock domain.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_wr_ctrl.sv | 94 +++++++++
 tb/tb_fifo_wr_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared pointer-encoding helpers for the async FIFO write/read controllers and top.
// Functions work on a fixed maximum width; callers zero-extend narrower pointers.
package fifo_pkg;

  localparam int PTR_MAX_W = 32;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Zero-extended inputs keep the upper result bits zero, so truncation is exact.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
    logic [PTR_MAX_W-1:0] bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller of the async FIFO: write pointer, RAM write port,
// full/almost_full/level/overflow flags and Gray pointer export.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDRWIDTH = 8,
  parameter int AF_MARGIN = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic                 clr_overflow,
  input  logic [ADDRWIDTH:0]   rptr_sync,
  output logic [ADDRWIDTH:0]   wptr_gray,
  output logic                 ram_we,
  output logic [ADDRWIDTH-1:0] ram_waddr,
  output logic                 full,
  output logic                 almost_full,
  output logic [ADDRWIDTH:0]   wr_level,
  output logic                 overflow
);

  localparam int PW    = ADDRWIDTH + 1;
  localparam int PAD   = PTR_MAX_W - PW;
  localparam int DEPTH = 1 << ADDRWIDTH;
  localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);

  logic [PW-1:0] r_wbin;
  logic [PW-1:0] r_wgray;
  logic          r_full;
  logic          r_almost_full;
  logic [PW-1:0] r_level;
  logic          r_overflow;

  logic                 w_accept;
  logic [PW-1:0]        w_wbin_next;
  logic [PTR_MAX_W-1:0] w_wgray_ext;
  logic [PW-1:0]        w_wgray_next;
  logic [PTR_MAX_W-1:0] w_rbin_ext;
  logic [PW-1:0]        w_rbin;
  logic [PW-1:0]        w_full_pattern;
  logic [PW-1:0]        w_level_next;
  logic                 w_full_next;
  logic                 w_almost_full_next;
  logic                 w_unused_hi;

  // Registered full gates the write, so a blocked request never reaches the RAM.
  assign w_accept    = wr_en & ~r_full;
  assign w_wbin_next = r_wbin + PW'(w_accept);

  assign w_wgray_ext  = bin2gray({{PAD{1'b0}}, w_wbin_next});
  assign w_wgray_next = w_wgray_ext[PW-1:0];
  assign w_rbin_ext   = gray2bin({{PAD{1'b0}}, rptr_sync});
  assign w_rbin       = w_rbin_ext[PW-1:0];
  assign w_unused_hi  = ^{w_wgray_ext[PTR_MAX_W-1:PW], w_rbin_ext[PTR_MAX_W-1:PW]};

  // In Gray code, "one lap ahead" means the two MSBs inverted and the rest equal.
  assign w_full_pattern     = {~rptr_sync[PW-1:PW-2], rptr_sync[PW-3:0]};
  assign w_full_next        = (w_wgray_next == w_full_pattern);
  assign w_level_next       = w_wbin_next - w_rbin;
  assign w_almost_full_next = (w_level_next >= AF_THRESH);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wbin        <= '0;
      r_wgray       <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_level       <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_wbin        <= w_wbin_next;
      r_wgray       <= w_wgray_next;
      r_full        <= w_full_next;
      r_almost_full <= w_almost_full_next;
      r_level       <= w_level_next;
      // A blocked write in the same cycle as a clear keeps the flag set.
      if (wr_en & r_full) begin
        r_overflow <= 1'b1;
      end else if (clr_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign ram_we      = w_accept;
  assign ram_waddr   = r_wbin[ADDRWIDTH-1:0];
  assign wptr_gray   = r_wgray;
  assign full        = r_full;
  assign almost_full = r_almost_full;
  assign wr_level    = r_level;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl: directed scenarios plus randomized traffic
// checked against a write/read count model (ADDRWIDTH=8, AF_MARGIN=4).
module tb_fifo_wr_ctrl;

  localparam int AW    = 8;
  localparam int DEPTH = 256;
  localparam int AFM   = 4;

  logic          clock;
  logic          reset;
  logic          wr_en;
  logic          clr_overflow;
  logic [AW:0]   rptr_sync;
  logic [AW:0]   wptr_gray;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic          full;
  logic          almost_full;
  logic [AW:0]   wr_level;
  logic          overflow;

  fifo_wr_ctrl #(.ADDRWIDTH(AW), .AF_MARGIN(AFM)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .clr_overflow(clr_overflow),
    .rptr_sync(rptr_sync), .wptr_gray(wptr_gray), .ram_we(ram_we),
    .ram_waddr(ram_waddr), .full(full), .almost_full(almost_full),
    .wr_level(wr_level), .overflow(overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Model: total writes accepted and total reads seen, as plain integers.
  int m_wr = 0;
  int m_rd = 0;
  bit m_full = 0;
  bit m_ovf = 0;

  function automatic logic [AW:0] gray_of(input int n);
    logic [AW:0] b;
    b = AW'(0) + n[AW:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check write port, clock, update model, check registered outputs.
  task automatic cycle(input bit wr, input bit clr, input int rd_total);
    bit acc;
    int lvl;
    wr_en = wr;
    clr_overflow = clr;
    m_rd = rd_total;
    rptr_sync = gray_of(m_rd);
    #1;
    acc = wr && !m_full;
    chk("ram_we", 32'(ram_we), 32'(acc));
    chk("ram_waddr", 32'(ram_waddr), 32'(m_wr % DEPTH));
    @(posedge clock);
    if (wr && m_full) m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (acc) m_wr++;
    lvl = m_wr - m_rd;
    m_full = (lvl == DEPTH);
    #1;
    chk("wptr_gray", 32'(wptr_gray), 32'(gray_of(m_wr)));
    chk("wr_level", 32'(wr_level), 32'(lvl));
    chk("full", 32'(full), 32'(m_full));
    chk("almost_full", 32'(almost_full), 32'(lvl >= DEPTH - AFM));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    @(negedge clock);
  endtask

  task automatic do_reset(input bit wr);
    reset = 1'b1;
    wr_en = wr;
    clr_overflow = 1'b0;
    rptr_sync = '0;
    @(posedge clock);
    m_wr = 0; m_rd = 0; m_full = 0; m_ovf = 0;
    #1;
    reset = 1'b0;
    wr_en = 1'b0;
    #1;
    chk("rst_wptr_gray", 32'(wptr_gray), 32'h0);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_almost_full", 32'(almost_full), 32'h0);
    chk("rst_wr_level", 32'(wr_level), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_ram_we", 32'(ram_we), 32'h0);
    chk("rst_ram_waddr", 32'(ram_waddr), 32'h0);
    @(negedge clock);
  endtask

  initial begin
    int hist[$];
    int start_wr;
    int rd;
    reset = 1'b1; wr_en = 1'b0; clr_overflow = 1'b0; rptr_sync = '0;
    @(negedge clock);
    do_reset(1'b0);

    // Fill with the reader parked at zero.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 0);
    chk("fill_gray", 32'(wptr_gray), 32'h180);
    chk("fill_level", 32'(wr_level), 32'd256);
    chk("fill_full", 32'(full), 32'h1);

    // Blocked writes, then clear the sticky flag.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 0);
    chk("ovf_set", 32'(overflow), 32'h1);
    chk("ovf_frozen", 32'(wptr_gray), 32'h180);
    cycle(1'b0, 1'b1, 0);
    chk("ovf_clr", 32'(overflow), 32'h0);

    // One read frees a slot, one write refills it.
    cycle(1'b0, 1'b0, 1);
    chk("drain_full", 32'(full), 32'h0);
    chk("drain_level", 32'(wr_level), 32'd255);
    cycle(1'b1, 1'b0, 1);
    chk("refill_full", 32'(full), 32'h1);
    chk("refill_gray", 32'(wptr_gray), 32'h181);

    // Simultaneous write and read at level 255.
    cycle(1'b0, 1'b0, 2);
    cycle(1'b1, 1'b0, 3);
    chk("simul_level", 32'(wr_level), 32'd255);
    chk("simul_full", 32'(full), 32'h0);
    chk("simul_af", 32'(almost_full), 32'h1);

    // Drain, then mirror the write pointer back with a two-cycle delay.
    cycle(1'b0, 1'b0, m_wr);
    hist.delete();
    hist.push_back(m_wr);
    hist.push_back(m_wr);
    start_wr = m_wr;
    for (int c = 0; c < 5000 && (m_wr - start_wr) < 1000; c++) begin
      cycle(($urandom % 4) != 0, 1'b0, hist.pop_front());
      hist.push_back(m_wr);
      chk("wrap_level_max2", 32'(wr_level <= 2), 32'h1);
    end
    chk("wrap_done", 32'((m_wr - start_wr) >= 1000), 32'h1);

    // Random traffic: write-heavy to reach full/overflow, then read-heavy.
    rd = m_rd;
    for (int c = 0; c < 1600; c++) begin
      bit heavy_wr;
      heavy_wr = (c < 900);
      if (rd < m_wr && ($urandom % (heavy_wr ? 4 : 1)) == 0) begin
        int room;
        room = (m_wr - rd) < 3 ? (m_wr - rd) : 3;
        rd += $urandom_range(1, room);
      end
      cycle(heavy_wr ? (($urandom % 8) != 0) : (($urandom % 3) == 0),
            ($urandom % 16) == 0, rd);
    end

    // Reset in the middle of traffic at level 100.
    do_reset(1'b0);
    for (int i = 0; i < 100; i++) cycle(1'b1, 1'b0, 0);
    chk("pre_rst_level", 32'(wr_level), 32'd100);
    do_reset(1'b1);
    wr_en = 1'b1; rptr_sync = '0;
    #1;
    chk("post_rst_waddr", 32'(ram_waddr), 32'h0);
    chk("post_rst_we", 32'(ram_we), 32'h1);
    cycle(1'b1, 1'b0, 0);
    chk("post_rst_level", 32'(wr_level), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
